pp_frame_sink: RTL and testbench
================================

// Module: pp_frame_sink
// PURPOSE
//  Consumer end of the ping-pong byte stream. Captures fixed-length frames of DEPTH
//  bytes into two alternating banks and replays each completed frame in order on a
//  valid/ready output stream. Exerts backpressure upstream via busy when both banks
//  hold unread frames. Sits between the ping-pong producer and downstream logic that
//  may stall.
// PARAMETERS
//  DATA_W  8   byte width of in/out
//  DEPTH   64  bytes per frame = bank size (>=2, need not be a power of 2)
//  ADDR_W  6   counter width, = clog2(DEPTH)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  in_vaild   in   1       input byte valid
//  in         in   DATA_W  input byte
//  busy       out  1       both banks full; input bytes are not accepted
//  out_vaild  out  1       out/out_last valid
//  out_ready  in   1       downstream accepts the current byte
//  out        out  DATA_W  output byte
//  out_last   out  1       marks the last byte of a frame
//  ovf        out  1       sticky: an input byte was dropped while busy
// BEHAVIOUR
//  Reset (async, rst_n=0): busy=0, out_vaild=0, out=0, out_last=0, ovf=0.
//    wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full[1:0]=0. Bank RAM is not cleared.
//    Partial or unread frames are discarded.
//  State: per-bank full flag; write pointer (wr_bank, wr_cnt); read pointer
//    (rd_bank, rd_cnt). Bank RAM is a flop array with combinational read.
//  busy = full[wr_bank]. It is decoded from flops only; there is no path from in_vaild.
//  Write: on in_vaild && !busy, store mem[wr_bank][wr_cnt] <= in.
//    - If wr_cnt==DEPTH-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0.
//    - Otherwise: wr_cnt+1.
//  Drop: on in_vaild && busy, the byte is discarded, ovf<=1 (held until reset),
//    and the pointers are unchanged.
//  Output is a registered stage. It loads when (!out_vaild || out_ready) && full[rd_bank]:
//    - out<=mem[rd_bank][rd_cnt], out_vaild<=1, out_last<=(rd_cnt==DEPTH-1).
//    - If rd_cnt==DEPTH-1: full[rd_bank]<=0, rd_bank toggles, rd_cnt<=0.
//    - Otherwise: rd_cnt+1.
//  When out_vaild && out_ready and no load occurs: out_vaild<=0, out_last<=0.
//    out holds its last value.
//  Stall: while out_vaild && !out_ready, out and out_last are held stable.
//  Throughput: 1 byte/cycle with out_ready=1 and frames available; no bubble
//    between frames.
//  Latency: last byte of a frame accepted at edge k -> full set at k ->
//    first byte of that frame on out with out_vaild=1 after edge k+1.
//  Bank release: the full flag clears when the last byte loads into the output
//    register (before it is consumed). busy drops on the next edge if the writer
//    was waiting on that bank.
//  Simultaneous set/clear of full in one cycle always targets different banks.
//    A bank is never written while full, so no read/write hazard exists.
//  Frame alignment is positional only; no resync. Recovery from misalignment is
//    by reset.
// TESTING
//  1 Reset, send 0x00..0x3F back-to-back with out_ready=1 -> out=0x00..0x3F
//    contiguous, out_last only on 0x3F, first out_vaild 1 cycle after byte 0x3F edge.
//  2 out_ready=0, send 129 bytes -> busy=1 after byte 128 accepted, byte 129
//    dropped, ovf=1; set out_ready=1 -> 128 bytes in order, busy=0 one cycle after
//    frame 0 last byte loaded.
//  3 Two frames, out_ready toggling 1/0 each cycle -> out stable during stalls,
//    no duplicate or lost byte, exactly 2 out_last pulses.
//  4 256 bytes continuous, out_ready=1 -> busy never 1, ovf=0, output contiguous
//    across 4 frames with bank alternation.
//  5 Reset asserted mid-frame (after byte 30) with out_vaild=1 -> all outputs 0
//    immediately; then frame 0xA0.. -> exactly 64 new bytes, no stale data.
//  6 DEPTH=5, ADDR_W=3, 3 frames -> counters wrap at 4, out_last every 5th byte,
//    order preserved.

Source files
------------

// File: rtl/pp_frame_sink.sv
// pp_frame_sink -- consumer end of the ping-pong byte stream.
//
// Captures fixed-length frames of DEPTH bytes into two alternating banks.
// Each completed frame is replayed in order on a valid/ready output stream.
// When both banks hold unread frames, busy tells the producer to stop.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_vaild   input byte valid
//   in         input byte (DATA_W)
//   busy       write bank is full; input bytes are dropped
//   out_vaild  out/out_last valid
//   out_ready  downstream accepts the current byte
//   out        output byte (DATA_W), registered
//   out_last   last byte of a frame
//   ovf        sticky: a byte was dropped while busy

// One frame bank: flop array with a single write port and a combinational read.
// It is not reset, because its contents are only read after a full frame has
// been written into it.
module pp_frame_sink_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  assign o_rdata = r_mem[i_raddr];
endmodule

module pp_frame_sink #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vaild,
  input  logic [DATA_W-1:0] in,
  output logic              busy,
  output logic              out_vaild,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic              out_last,
  output logic              ovf
);
  localparam int            NB    = 2;
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  logic [NB-1:0]             r_full;
  logic                      r_wr_bank;
  logic [ADDR_W-1:0]         r_wr_cnt;
  logic                      r_rd_bank;
  logic [ADDR_W-1:0]         r_rd_cnt;
  logic [DATA_W-1:0]         r_out;
  logic                      r_out_vaild;
  logic                      r_out_last;
  logic                      r_ovf;

  logic                      w_busy;
  logic                      w_wr_fire;
  logic                      w_wr_last;
  logic                      w_ld;
  logic                      w_rd_last;
  logic [NB-1:0]             w_full_nxt;
  logic [NB-1:0][DATA_W-1:0] w_bank_rdata;
  logic [DATA_W-1:0]         w_rd_data;

  // busy comes from flops only, so there is no in_vaild -> busy path.
  assign w_busy    = r_full[r_wr_bank];
  assign w_wr_fire = in_vaild && !w_busy;
  assign w_wr_last = (r_wr_cnt == CNT_LAST);

  // The output register loads whenever it is empty or being drained, and the
  // read bank holds a complete frame.
  assign w_ld      = (!r_out_vaild || out_ready) && r_full[r_rd_bank];
  assign w_rd_last = (r_rd_cnt == CNT_LAST);
  assign w_rd_data = w_bank_rdata[r_rd_bank];

  for (genvar b = 0; b < NB; b++) begin : g_bank
    pp_frame_sink_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk     (clk),
      .i_we    (w_wr_fire && (r_wr_bank == 1'(b))),
      .i_waddr (r_wr_cnt),
      .i_wdata (in),
      .i_raddr (r_rd_cnt),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // The writer only targets a free bank and the reader only releases a full
  // one, so a set and a clear in the same cycle always hit different banks.
  // The release happens when the last byte enters the output register, which
  // lets the writer restart one cycle later.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_fire && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_ld && w_rd_last)      w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_out       <= '0;
      r_out_vaild <= 1'b0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_full <= w_full_nxt;

      if (w_wr_fire) begin
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
          r_wr_cnt  <= '0;
        end else begin
          r_wr_cnt  <= r_wr_cnt + 1'b1;
        end
      end

      // A dropped byte leaves the pointers alone; only the sticky flag moves.
      if (in_vaild && w_busy) r_ovf <= 1'b1;

      if (w_ld) begin
        r_out       <= w_rd_data;
        r_out_vaild <= 1'b1;
        r_out_last  <= w_rd_last;
        if (w_rd_last) begin
          r_rd_bank <= ~r_rd_bank;
          r_rd_cnt  <= '0;
        end else begin
          r_rd_cnt  <= r_rd_cnt + 1'b1;
        end
      end else if (r_out_vaild && out_ready) begin
        // Drained with nothing behind it; out keeps its last value.
        r_out_vaild <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign busy      = w_busy;
  assign out_vaild = r_out_vaild;
  assign out       = r_out;
  assign out_last  = r_out_last;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_pp_frame_sink.sv
// Bench for pp_frame_sink. Two instances share one stimulus stream:
// index 0 uses DEPTH=64, index 1 uses DEPTH=5 (non-power-of-2 wrap).
// A frame-level reference model runs on each posedge; a monitor on the
// negedge pops the scoreboard on every output handshake.
module tb_pp_frame_sink;
  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  localparam int DEP [2] = '{64, 5};

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_vaild = 1'b0;
  logic [7:0]      din = '0;
  logic            out_ready = 1'b0;
  logic [1:0]      busy, ov, ol, ovf;
  logic [1:0][7:0] dout;

  int checks = 0;
  int errors = 0;

  // reference model state, per instance
  int         m_held [2];   // complete frames not yet fully loaded to out
  int         m_rd_idx [2]; // bytes of the head frame already loaded
  bit         m_ov [2];
  bit         m_ovf [2];
  int         m_frames [2];
  logic [7:0] pend [2][$];  // partial frame being captured
  exp_t       sb [2][$];    // bytes of complete frames awaiting output

  // monitor statistics
  int n_out [2];
  int n_last [2];
  bit busy_seen [2];

  pp_frame_sink #(.DATA_W(8), .DEPTH(64), .ADDR_W(6)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_vaild(in_vaild), .in(din), .busy(busy[0]),
    .out_vaild(ov[0]), .out_ready(out_ready), .out(dout[0]),
    .out_last(ol[0]), .ovf(ovf[0])
  );

  pp_frame_sink #(.DATA_W(8), .DEPTH(5), .ADDR_W(3)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .in_vaild(in_vaild), .in(din), .busy(busy[1]),
    .out_vaild(ov[1]), .out_ready(out_ready), .out(dout[1]),
    .out_last(ol[1]), .ovf(ovf[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: busy means both banks hold frames not yet fully handed
  // to the output register; the output slot refills whenever it is empty or
  // accepted. Decisions use the pre-edge frame count.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_held[i] = 0; m_rd_idx[i] = 0; m_ov[i] = 0; m_ovf[i] = 0;
        pend[i].delete(); sb[i].delete();
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit ld, wr;
        int h;
        h  = m_held[i];
        ld = (!m_ov[i] || out_ready) && (h > 0);
        wr = in_vaild && (h < 2);
        if (ld) begin
          m_ov[i] = 1;
          m_rd_idx[i]++;
          if (m_rd_idx[i] == DEP[i]) begin
            m_rd_idx[i] = 0;
            m_held[i]--;
          end
        end else if (out_ready) begin
          m_ov[i] = 0;
        end
        if (wr) begin
          pend[i].push_back(din);
          if (pend[i].size() == DEP[i]) begin
            for (int j = 0; j < DEP[i]; j++) begin
              exp_t e;
              e.d = pend[i][j];
              e.last = (j == DEP[i] - 1);
              sb[i].push_back(e);
            end
            pend[i].delete();
            m_held[i]++;
            m_frames[i]++;
          end
        end else if (in_vaild) begin
          m_ovf[i] = 1;
        end
      end
    end
  end

  // Monitor: status compare every cycle, scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, 32'(busy[i]), 32'(m_held[i] == 2));
        chk("ovf", i, 32'(ovf[i]), 32'(m_ovf[i]));
        chk("out_vaild", i, 32'(ov[i]), 32'(m_ov[i]));
        if (busy[i]) busy_seen[i] = 1;
        if (ov[i] && out_ready) begin
          n_out[i]++;
          if (ol[i]) n_last[i]++;
          if (sb[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out[dut%0d] got %0h expected none at %0t",
                     i, dout[i], $time);
          end else begin
            exp_t e;
            e = sb[i].pop_front();
            chk("out", i, 32'(dout[i]), 32'(e.d));
            chk("out_last", i, 32'(ol[i]), 32'(e.last));
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_vaild = 1'b0; out_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 2; i++) begin
      n_out[i] = 0; n_last[i] = 0; busy_seen[i] = 0; m_frames[i] = 0;
    end
  endtask

  task automatic drain(input int n, input bit toggle);
    in_vaild = 1'b0;
    for (int k = 0; k < n; k++) begin
      out_ready = toggle ? ~out_ready : 1'b1;
      cyc();
    end
    out_ready = 1'b1;
    cyc(); cyc();
    for (int i = 0; i < 2; i++) chk("sb_empty", i, 32'(sb[i].size()), 0);
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(busy[i]), 0);
      chk("rst_vld", i, 32'(ov[i]), 0);
      chk("rst_out", i, 32'(dout[i]), 0);
      chk("rst_last", i, 32'(ol[i]), 0);
      chk("rst_ovf", i, 32'(ovf[i]), 0);
    end
    do_reset();

    // 1: one frame 0x00..0x3F, ready held high
    clr_stats();
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      in_vaild = 1'b1; din = 8'(k); cyc();
    end
    drain(80, 0);
    chk("t1_nout", 0, 32'(n_out[0]), 64);
    chk("t1_nlast", 0, 32'(n_last[0]), 1);

    // 2: output stalled, 129 random bytes -> last one dropped on dut0
    do_reset();
    clr_stats();
    out_ready = 1'b0;
    for (int k = 0; k < 129; k++) begin
      in_vaild = 1'b1; din = 8'($urandom); cyc();
    end
    in_vaild = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    chk("t2_ovf", 0, 32'(ovf[0]), 1);
    chk("t2_busy", 0, 32'(busy[0]), 1);
    drain(200, 0);
    chk("t2_nout", 0, 32'(n_out[0]), 128);

    // 3: two frames with ready toggling every cycle
    do_reset();
    clr_stats();
    for (int k = 0; k < 128; k++) begin
      in_vaild = 1'b1; din = 8'($urandom); out_ready = ~out_ready; cyc();
    end
    drain(400, 1);
    chk("t3_nlast", 0, 32'(n_last[0]), 2);
    chk("t3_nlast", 1, 32'(n_last[1]), 32'(m_frames[1]));

    // 4: 256 bytes continuous, ready high -> never busy, no overflow
    do_reset();
    clr_stats();
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      in_vaild = 1'b1; din = 8'(k); cyc();
    end
    drain(80, 0);
    for (int i = 0; i < 2; i++) begin
      chk("t4_busy_seen", i, 32'(busy_seen[i]), 0);
      chk("t4_ovf", i, 32'(ovf[i]), 0);
    end
    chk("t4_nlast", 0, 32'(n_last[0]), 4);
    chk("t4_nlast", 1, 32'(n_last[1]), 51);

    // 5: reset mid-frame with a byte waiting on the output
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 94; k++) begin
      in_vaild = 1'b1; din = 8'($urandom_range(0, 255)); cyc();
    end
    in_vaild = 1'b0;
    chk("t5_vld_pre", 0, 32'(ov[0]), 1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("t5_busy", i, 32'(busy[i]), 0);
      chk("t5_vld", i, 32'(ov[i]), 0);
      chk("t5_out", i, 32'(dout[i]), 0);
      chk("t5_last", i, 32'(ol[i]), 0);
      chk("t5_ovf", i, 32'(ovf[i]), 0);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    clr_stats();
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      in_vaild = 1'b1; din = 8'(8'hA0 + k); cyc();
    end
    drain(80, 0);
    chk("t5_nout", 0, 32'(n_out[0]), 64);
    chk("t5_nout", 1, 32'(n_out[1]), 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
